tl_tx_credit_sched: RTL
=======================

# tl_tx_credit_sched

Credit-aware transmit scheduler for the transaction layer. It shares the single TX packet path between three requester classes: Posted (P), Non-Posted (NP) and Completion (CPL). It tracks header and data flow-control credits per class from DLL updates, and grants the path to one eligible class at a time with round-robin fairness. It holds the grant until the granted packet's last beat. It sits between the header generator / completion engine and the TX arbiter stage, and replaces the fixed `credit_ok` tie-off.

## Interface
Parameters:
- `HDR_CW`, 8: header credit counter width.
- `DATA_CW`, 12: data credit counter width (units of 4 DW).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_i`, in, 3: per-class request, bit0 = P, bit1 = NP, bit2 = CPL.
- `hdr_need_i`, in, 3×HDR_CW: header credits needed by each class's pending packet.
- `data_need_i`, in, 3×DATA_CW: data credits needed by each class's pending packet (0 for no payload).
- `gnt_o`, out, 3: one-hot grant, held for the whole packet.
- `pkt_done_i`, in, 1: last beat of the granted packet accepted downstream.
- `fc_valid_i`, in, 1: credit update strobe.
- `fc_class_i`, in, 2: class of the update (0 = P, 1 = NP, 2 = CPL; 3 is ignored).
- `fc_hdr_inc_i`, in, HDR_CW: header credits returned.
- `fc_data_inc_i`, in, DATA_CW: data credits returned.
- `hdr_avail_o`, out, 3×HDR_CW: current header credits per class.
- `data_avail_o`, out, 3×DATA_CW: current data credits per class.
- `busy_o`, out, 1: a grant is active.

## Operation
- **Class eligibility:** `eligible[c] = req_i[c] & (hdr_avail[c] >= hdr_need[c]) & (data_avail[c] >= data_need[c])`.
- **State IDLE:**
  - If any class is eligible, pick the first eligible class in round-robin order, starting after `rr_ptr`.
  - Register the one-hot grant, deduct that class's needs from its counters, set `rr_ptr` to the winner, and go to BUSY.
  - If nothing is eligible, stay in IDLE.
- **State BUSY:**
  - Hold `gnt_o` constant and ignore other requests.
  - On `pkt_done_i`, clear `gnt_o` and go to IDLE.
- **Requester rules:** Once `req_i[c]` is raised, `req_i[c]` and the class's needs stay stable until that class is granted. Dropping a request before grant is a protocol violation; the bench flags it.
- **Credit update:**
  - Each counter updates as `next = sat(avail + inc − consume)`.
  - `inc` is the update amount when `fc_valid_i` is high and the class matches, else 0.
  - `consume` is the need at the grant cycle, else 0.
  - The arithmetic is one bit wider than the counter. The result clamps to the all-ones maximum and never wraps.
  - An update and a grant on the same class in the same cycle are both applied.
- **Unexpected `pkt_done_i`:** `pkt_done_i` in IDLE is ignored.

## Timing
- **Reset values:** `gnt_o` = 0, `busy_o` = 0, all credit counters = 0, `rr_ptr` = CPL (so P has first priority), state = IDLE.
- **Grant latency:** `req_i` eligible at edge n gives `gnt_o` at edge n+1.
- **Between packets:** `pkt_done_i` at edge m clears `gnt_o` at m+1. The earliest next grant is at m+2, so there is one bubble between packets.
- **Credit visibility:** a credit update at edge k is visible in `*_avail_o` and in eligibility from edge k+1. A class blocked only by credits becomes grantable one cycle after the update.
- **`busy_o`:** equals `|gnt_o`, registered.
- **Reset during BUSY:** the grant drops at the next edge and credits return to 0. Credits taken by the in-flight packet are not restored.

## Configuration
- **Macro `TL_SCHED_PERF_EN`.**
- **Defined:** adds outputs `perf_gnt_cnt_o` (3×32, per-class grant count) and `perf_stall_cnt_o` (32, cycles in IDLE with `req_i` ≠ 0 but no eligible class). The counters wrap and reset to 0.
- **Undefined:** these ports and counters do not exist.

## Structure
- **Shared package `tl_pkg`:**
  - `tl_fc_class_e` enum (P = 0, NP = 1, CPL = 2).
  - The `HDR_CW` / `DATA_CW` default constants.
  - `tl_sched_state_e` (IDLE, BUSY).
- **Sub-module `tl_credit_ctr`:** one instance per class, each holding the header and data saturating add/subtract counter pair.
- **Top of this block:** the FSM, round-robin pick and grant register.

## Test plan
- **Basic grant:** reset, then P update (hdr 4, data 16), then P request (need 1 hdr / 8 data). Required: `gnt_o` = 001 one cycle later, avail = 3/8, `pkt_done_i` returns to IDLE.
- **Credit blocking:** NP request (need 1/0) with NP hdr 0. Required: no grant, stall counter increments if `TL_SCHED_PERF_EN` is defined. An NP update of hdr 1 gives a grant 1 cycle later and hdr_avail NP = 0.
- **Round-robin:** all three classes with ample credits, continuous requests over 6 packets. Required: grant order P, NP, CPL, P, NP, CPL, with exactly one idle cycle between packets.
- **Simultaneous update and grant:** CPL data avail 10, a CPL update of +5 data in the same cycle as a grant needing 8. Required: data_avail CPL = 7.
- **Saturation:** P hdr at 250 plus an update of +10. Required: 255, then a grant with need 5 gives 250.
- **Reset mid-packet:** assert `rst` while `gnt_o` = 010. Required: next cycle `gnt_o` = 0, `busy_o` = 0, all avail = 0, and the next grant goes to P first.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared transaction-layer types: flow-control classes, scheduler states, credit widths.
// Latency: n/a (types only). Backpressure: n/a.
package tl_pkg;

    localparam int TL_HDR_CW  = 8;
    localparam int TL_DATA_CW = 12;
    localparam int TL_NUM_CLS = 3;

    typedef enum logic [1:0] {
        TL_FC_P   = 2'd0,
        TL_FC_NP  = 2'd1,
        TL_FC_CPL = 2'd2
    } tl_fc_class_e;

    typedef enum logic {
        TL_IDLE = 1'b0,
        TL_BUSY = 1'b1
    } tl_sched_state_e;

    // Round-robin successor over the three classes (P -> NP -> CPL -> P).
    function automatic logic [1:0] tl_rr_next(input logic [1:0] cls);
        return (cls >= 2'd2) ? 2'd0 : cls + 2'd1;
    endfunction

endpackage

// File: rtl/tl_credit_ctr.sv
// Per-class header/data flow-control credit counter pair with saturating add/consume.
// Latency: update or consume at edge k is visible at k+1. Backpressure: none, always accepts.
module tl_credit_ctr #(
    parameter int HDR_CW  = 8,
    parameter int DATA_CW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_vld,
    input  logic [HDR_CW-1:0]  hdr_inc,
    input  logic [DATA_CW-1:0] data_inc,
    input  logic               consume,
    input  logic [HDR_CW-1:0]  hdr_need,
    input  logic [DATA_CW-1:0] data_need,
    output logic [HDR_CW-1:0]  hdr_avail,
    output logic [DATA_CW-1:0] data_avail
);

    logic [HDR_CW:0]  hdr_sum;
    logic [DATA_CW:0] data_sum;

    // Consume only happens on an eligible grant, so avail + inc >= need and the
    // extra bit only ever signals overflow, never borrow.
    always_comb begin
        hdr_sum  = {1'b0, hdr_avail}
                 + (inc_vld ? {1'b0, hdr_inc} : '0)
                 - (consume ? {1'b0, hdr_need} : '0);
        data_sum = {1'b0, data_avail}
                 + (inc_vld ? {1'b0, data_inc} : '0)
                 - (consume ? {1'b0, data_need} : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_avail  <= '0;
            data_avail <= '0;
        end else begin
            hdr_avail  <= hdr_sum[HDR_CW]   ? '1 : hdr_sum[HDR_CW-1:0];
            data_avail <= data_sum[DATA_CW] ? '1 : data_sum[DATA_CW-1:0];
        end
    end

endmodule

// File: rtl/tl_tx_credit_sched.sv
// Credit-aware round-robin TX scheduler for P/NP/CPL; optional perf counters under TL_SCHED_PERF_EN.
// Latency: eligible request at edge n -> grant at n+1; one bubble between packets. Backpressure: grant held until pkt_done_i.
module tl_tx_credit_sched
    import tl_pkg::*;
#(
    parameter int HDR_CW  = TL_HDR_CW,
    parameter int DATA_CW = TL_DATA_CW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req_i,
    input  logic [2:0][HDR_CW-1:0]  hdr_need_i,
    input  logic [2:0][DATA_CW-1:0] data_need_i,
    output logic [2:0]              gnt_o,
    input  logic                    pkt_done_i,
    input  logic                    fc_valid_i,
    input  logic [1:0]              fc_class_i,
    input  logic [HDR_CW-1:0]       fc_hdr_inc_i,
    input  logic [DATA_CW-1:0]      fc_data_inc_i,
    output logic [2:0][HDR_CW-1:0]  hdr_avail_o,
    output logic [2:0][DATA_CW-1:0] data_avail_o,
    output logic                    busy_o
`ifdef TL_SCHED_PERF_EN
    ,
    output logic [2:0][31:0]        perf_gnt_cnt_o,
    output logic [31:0]             perf_stall_cnt_o
`endif
);

    tl_sched_state_e state;
    logic [1:0]      rr_ptr;
    logic [2:0]      eligible;
    logic [2:0]      inc_vld;
    logic [2:0]      consume;
    logic            win_vld;
    logic [1:0]      win_idx;
    logic [1:0]      cand;
    logic            grant_fire;

    always_comb begin
        eligible = '0;
        inc_vld  = '0;
        for (int c = 0; c < TL_NUM_CLS; c++) begin
            eligible[c] = req_i[c]
                        && (hdr_avail_o[c]  >= hdr_need_i[c])
                        && (data_avail_o[c] >= data_need_i[c]);
            inc_vld[c]  = fc_valid_i && (fc_class_i == 2'(c));
        end
    end

    // Search starts one past the last winner so every class gets a turn.
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr;
        cand    = rr_ptr;
        for (int i = 0; i < TL_NUM_CLS; i++) begin
            cand = tl_rr_next(cand);
            if (!win_vld && eligible[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign grant_fire = (state == TL_IDLE) && win_vld;

    always_comb begin
        consume = '0;
        for (int c = 0; c < TL_NUM_CLS; c++) begin
            consume[c] = grant_fire && (win_idx == 2'(c));
        end
    end

    for (genvar c = 0; c < TL_NUM_CLS; c++) begin : g_ctr
        tl_credit_ctr #(
            .HDR_CW  (HDR_CW),
            .DATA_CW (DATA_CW)
        ) u_ctr (
            .clk        (clk),
            .rst        (rst),
            .inc_vld    (inc_vld[c]),
            .hdr_inc    (fc_hdr_inc_i),
            .data_inc   (fc_data_inc_i),
            .consume    (consume[c]),
            .hdr_need   (hdr_need_i[c]),
            .data_need  (data_need_i[c]),
            .hdr_avail  (hdr_avail_o[c]),
            .data_avail (data_avail_o[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= TL_IDLE;
            gnt_o  <= '0;
            busy_o <= 1'b0;
            rr_ptr <= TL_FC_CPL;
        end else begin
            case (state)
                TL_IDLE: begin
                    if (win_vld) begin
                        gnt_o  <= 3'b001 << win_idx;
                        busy_o <= 1'b1;
                        rr_ptr <= win_idx;
                        state  <= TL_BUSY;
                    end
                end
                TL_BUSY: begin
                    if (pkt_done_i) begin
                        gnt_o  <= '0;
                        busy_o <= 1'b0;
                        state  <= TL_IDLE;
                    end
                end
                default: state <= TL_IDLE;
            endcase
        end
    end

`ifdef TL_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_gnt_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (grant_fire) begin
                perf_gnt_cnt_o[win_idx] <= perf_gnt_cnt_o[win_idx] + 32'd1;
            end
            if ((state == TL_IDLE) && (|req_i) && !win_vld) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
